// File: rtl/caminho_saida_lifo.sv
// Path output LIFO: buffers one reconstructed path (DESTINO first) and replays it FONTE first
// over a valid/ready stream, reporting path length, completion pulse and sticky overflow.
module caminho_saida_lifo #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned MAX_CAMINHO = 64,
    parameter int unsigned CNT_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  anterior_valid_in,
    input  logic [ADDR_WIDTH-1:0] anterior_addr_in,
    input  logic                  anterior_last_in,
    output logic                  anterior_ready_out,
    output logic                  saida_valid_out,
    output logic [ADDR_WIDTH-1:0] saida_addr_out,
    output logic                  saida_last_out,
    input  logic                  saida_ready_in,
    output logic [CNT_WIDTH-1:0]  tamanho_out,
    output logic                  pronto_out,
    output logic                  erro_out
);

    localparam int unsigned IDX_WIDTH = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_CAMINHO);

    typedef enum logic {S_CARREGA, S_DESCARREGA} estado_e;

    estado_e                estado_q, estado_d;
    logic [CNT_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]   tamanho_q, tamanho_d;
    logic                   erro_q, erro_d;
    logic                   pronto_q, pronto_d;
    logic                   ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0]  mem_q [MAX_CAMINHO];

    logic                   mem_we;
    logic                   cheio;
    logic [IDX_WIDTH-1:0]   wr_idx;
    logic [IDX_WIDTH-1:0]   rd_idx;

    assign cheio  = (ptr_q == CNT_MAX);
    assign wr_idx = IDX_WIDTH'(ptr_q);
    assign rd_idx = IDX_WIDTH'(ptr_q - CNT_ONE);

    always_comb begin
        estado_d  = estado_q;
        ptr_d     = ptr_q;
        tamanho_d = tamanho_q;
        erro_d    = erro_q;
        pronto_d  = 1'b0;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        case (estado_q)
            S_CARREGA: begin
                if (anterior_valid_in) begin
                    if (cheio) begin
                        erro_d = 1'b1;
                        ovf_d  = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        ptr_d  = ptr_q + CNT_ONE;
                    end
                    if (anterior_last_in) begin
                        ovf_d = 1'b0;
                        // A path that lost any node is discarded whole, never replayed.
                        if (ovf_q || cheio) begin
                            ptr_d = '0;
                        end else begin
                            tamanho_d = ptr_q + CNT_ONE;
                            estado_d  = S_DESCARREGA;
                        end
                    end
                end
            end
            S_DESCARREGA: begin
                if (saida_ready_in) begin
                    ptr_d = ptr_q - CNT_ONE;
                    if (ptr_q == CNT_ONE) begin
                        ptr_d    = '0;
                        estado_d = S_CARREGA;
                        pronto_d = 1'b1;
                    end
                end
            end
            default: estado_d = S_CARREGA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= S_CARREGA;
            ptr_q     <= '0;
            tamanho_q <= '0;
            erro_q    <= 1'b0;
            pronto_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ptr_q     <= ptr_d;
            tamanho_q <= tamanho_d;
            erro_q    <= erro_d;
            pronto_q  <= pronto_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset; only ptr decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx] <= anterior_addr_in;
        end
    end

    always_comb begin
        anterior_ready_out = (estado_q == S_CARREGA);
        saida_valid_out    = (estado_q == S_DESCARREGA);
        saida_addr_out     = '0;
        saida_last_out     = 1'b0;
        if (estado_q == S_DESCARREGA) begin
            saida_addr_out = mem_q[rd_idx];
            saida_last_out = (ptr_q == CNT_ONE);
        end
    end

    assign tamanho_out = tamanho_q;
    assign pronto_out  = pronto_q;
    assign erro_out    = erro_q;

endmodule

// File: tb/tb_caminho_saida_lifo.sv
// Directed bench for caminho_saida_lifo: a default-depth instance plus a depth-4 instance
// used for the overflow scenario.
module tb_caminho_saida_lifo;

    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;

    // Default instance (MAX_CAMINHO = 64)
    logic       a_valid, a_last, a_ready, s_valid, s_last, s_ready, pronto, erro;
    logic [7:0] a_addr, s_addr;
    logic [6:0] tamanho;

    // Small instance (MAX_CAMINHO = 4)
    logic       p_a_valid, p_a_last, p_a_ready, p_s_valid, p_s_last, p_s_ready, p_pronto, p_erro;
    logic [7:0] p_a_addr, p_s_addr;
    logic [2:0] p_tamanho;

    always #5 clk = ~clk;

    caminho_saida_lifo dut (
        .clk               (clk),
        .rst               (rst),
        .anterior_valid_in (a_valid),
        .anterior_addr_in  (a_addr),
        .anterior_last_in  (a_last),
        .anterior_ready_out(a_ready),
        .saida_valid_out   (s_valid),
        .saida_addr_out    (s_addr),
        .saida_last_out    (s_last),
        .saida_ready_in    (s_ready),
        .tamanho_out       (tamanho),
        .pronto_out        (pronto),
        .erro_out          (erro)
    );

    caminho_saida_lifo #(
        .ADDR_WIDTH (8),
        .MAX_CAMINHO(4)
    ) dut_p (
        .clk               (clk),
        .rst               (rst),
        .anterior_valid_in (p_a_valid),
        .anterior_addr_in  (p_a_addr),
        .anterior_last_in  (p_a_last),
        .anterior_ready_out(p_a_ready),
        .saida_valid_out   (p_s_valid),
        .saida_addr_out    (p_s_addr),
        .saida_last_out    (p_s_last),
        .saida_ready_in    (p_s_ready),
        .tamanho_out       (p_tamanho),
        .pronto_out        (p_pronto),
        .erro_out          (p_erro)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] addr, input logic last);
        a_valid = 1'b1;
        a_addr  = addr;
        a_last  = last;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic push_p(input logic [7:0] addr, input logic last);
        p_a_valid = 1'b1;
        p_a_addr  = addr;
        p_a_last  = last;
        tick();
        p_a_valid = 1'b0;
        p_a_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({a_ready, s_valid, s_last, s_addr} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b last=%0b addr=%0d want 1 0 0 0",
                     a_ready, s_valid, s_last, s_addr);
        end
        total++;
        if ({tamanho, pronto, erro} !== {7'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_status: got tam=%0d pronto=%0b erro=%0b want 0 0 0",
                     tamanho, pronto, erro);
        end
        total++;
        if ({p_a_ready, p_s_valid, p_tamanho, p_erro} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_small: got rdy=%0b vld=%0b tam=%0d erro=%0b want 1 0 0 0",
                     p_a_ready, p_s_valid, p_tamanho, p_erro);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_addr [4];
        exp_addr = '{8'd3, 8'd12, 8'd9, 8'd5};
        s_ready = 1'b1;
        push(8'd5, 1'b0);
        push(8'd9, 1'b0);
        push(8'd12, 1'b0);
        push(8'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({s_valid, s_addr, s_last, a_ready} !== {1'b1, exp_addr[i], (i == 3), 1'b0}) begin
                bad++;
                $display("FAIL basic_out%0d: got vld=%0b addr=%0d last=%0b rdy=%0b want 1 %0d %0b 0",
                         i, s_valid, s_addr, s_last, a_ready, exp_addr[i], (i == 3));
            end
            tick();
        end
        total++;
        if ({pronto, s_valid, a_ready, tamanho} !== {1'b1, 1'b0, 1'b1, 7'd4}) begin
            bad++;
            $display("FAIL basic_done: got pronto=%0b vld=%0b rdy=%0b tam=%0d want 1 0 1 4",
                     pronto, s_valid, a_ready, tamanho);
        end
        tick();
        total++;
        if (pronto !== 1'b0) begin
            bad++;
            $display("FAIL basic_pronto_pulse: got %0b want 0", pronto);
        end
    endtask

    task automatic test_single();
        s_ready = 1'b1;
        push(8'd7, 1'b1);
        total++;
        if ({s_valid, s_addr, s_last, tamanho} !== {1'b1, 8'd7, 1'b1, 7'd1}) begin
            bad++;
            $display("FAIL single_out: got vld=%0b addr=%0d last=%0b tam=%0d want 1 7 1 1",
                     s_valid, s_addr, s_last, tamanho);
        end
        tick();
        total++;
        if ({pronto, a_ready, s_valid} !== {1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_done: got pronto=%0b rdy=%0b vld=%0b want 1 1 0",
                     pronto, a_ready, s_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_addr [4];
        logic       pat [7];
        int         hs;
        exp_addr = '{8'd3, 8'd12, 8'd9, 8'd5};
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        hs       = 0;
        s_ready  = 1'b0;
        push(8'd5, 1'b0);
        push(8'd9, 1'b0);
        push(8'd12, 1'b0);
        push(8'd3, 1'b1);
        for (int k = 0; k < 7; k++) begin
            s_ready = pat[k];
            total++;
            if ({s_valid, s_addr, s_last} !== {1'b1, exp_addr[hs], (hs == 3)}) begin
                bad++;
                $display("FAIL bp_cycle%0d: got vld=%0b addr=%0d last=%0b want 1 %0d %0b",
                         k, s_valid, s_addr, s_last, exp_addr[hs], (hs == 3));
            end
            if (s_valid && s_ready) hs++;
            tick();
        end
        s_ready = 1'b0;
        total++;
        if ({hs, pronto, s_valid} !== {32'd4, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL bp_done: got hs=%0d pronto=%0b vld=%0b want 4 1 0", hs, pronto, s_valid);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] seen_valid;
        seen_valid = 8'd0;
        p_s_ready  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_p(8'(i), (i == 5));
            if (p_s_valid) seen_valid++;
        end
        tick();
        if (p_s_valid) seen_valid++;
        total++;
        if ({seen_valid, p_erro, p_tamanho, p_a_ready} !== {8'd0, 1'b1, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL ovf_drop: got vld_cycles=%0d erro=%0b tam=%0d rdy=%0b want 0 1 0 1",
                     seen_valid, p_erro, p_tamanho, p_a_ready);
        end
        push_p(8'd8, 1'b0);
        push_p(8'd2, 1'b1);
        total++;
        if ({p_s_valid, p_s_addr, p_s_last, p_erro} !== {1'b1, 8'd2, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL ovf_next0: got vld=%0b addr=%0d last=%0b erro=%0b want 1 2 0 1",
                     p_s_valid, p_s_addr, p_s_last, p_erro);
        end
        tick();
        total++;
        if ({p_s_valid, p_s_addr, p_s_last, p_tamanho} !== {1'b1, 8'd8, 1'b1, 3'd2}) begin
            bad++;
            $display("FAIL ovf_next1: got vld=%0b addr=%0d last=%0b tam=%0d want 1 8 1 2",
                     p_s_valid, p_s_addr, p_s_last, p_tamanho);
        end
        tick();
        total++;
        if ({p_pronto, p_erro} !== {1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ovf_done: got pronto=%0b erro=%0b want 1 1", p_pronto, p_erro);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        s_ready = 1'b0;
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        push(8'd3, 1'b0);
        push(8'd4, 1'b1);
        s_ready = 1'b1;
        tick();
        tick();
        s_ready = 1'b0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        total++;
        if ({s_valid, a_ready, tamanho, erro, pronto} !== {1'b0, 1'b1, 7'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got vld=%0b rdy=%0b tam=%0d erro=%0b pronto=%0b want 0 1 0 0 0",
                     s_valid, a_ready, tamanho, erro, pronto);
        end
        total++;
        if (p_erro !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_erro_small: got %0b want 0", p_erro);
        end
        push(8'd4, 1'b0);
        push(8'd6, 1'b1);
        s_ready = 1'b1;
        total++;
        if ({s_valid, s_addr, s_last} !== {1'b1, 8'd6, 1'b0}) begin
            bad++;
            $display("FAIL mid_fresh0: got vld=%0b addr=%0d last=%0b want 1 6 0",
                     s_valid, s_addr, s_last);
        end
        tick();
        total++;
        if ({s_valid, s_addr, s_last, tamanho} !== {1'b1, 8'd4, 1'b1, 7'd2}) begin
            bad++;
            $display("FAIL mid_fresh1: got vld=%0b addr=%0d last=%0b tam=%0d want 1 4 1 2",
                     s_valid, s_addr, s_last, tamanho);
        end
        tick();
        tick();
    endtask

    task automatic test_held_valid();
        s_ready = 1'b0;
        push(8'd5, 1'b0);
        push(8'd9, 1'b1);
        a_valid = 1'b1;
        a_addr  = 8'd11;
        a_last  = 1'b1;
        tick();
        total++;
        if ({s_valid, s_addr, a_ready} !== {1'b1, 8'd9, 1'b0}) begin
            bad++;
            $display("FAIL held_stall: got vld=%0b addr=%0d rdy=%0b want 1 9 0",
                     s_valid, s_addr, a_ready);
        end
        s_ready = 1'b1;
        tick();
        total++;
        if ({s_valid, s_addr, s_last} !== {1'b1, 8'd5, 1'b1}) begin
            bad++;
            $display("FAIL held_second: got vld=%0b addr=%0d last=%0b want 1 5 1",
                     s_valid, s_addr, s_last);
        end
        tick();
        total++;
        if ({pronto, a_ready} !== {1'b1, 1'b1}) begin
            bad++;
            $display("FAIL held_pronto: got pronto=%0b rdy=%0b want 1 1", pronto, a_ready);
        end
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
        total++;
        if ({s_valid, s_addr, s_last, tamanho} !== {1'b1, 8'd11, 1'b1, 7'd1}) begin
            bad++;
            $display("FAIL held_emit: got vld=%0b addr=%0d last=%0b tam=%0d want 1 11 1 1",
                     s_valid, s_addr, s_last, tamanho);
        end
        tick();
        total++;
        if ({pronto, s_valid} !== {1'b1, 1'b0}) begin
            bad++;
            $display("FAIL held_done: got pronto=%0b vld=%0b want 1 0", pronto, s_valid);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_addr    = 8'd0;
        a_last    = 1'b0;
        s_ready   = 1'b0;
        p_a_valid = 1'b0;
        p_a_addr  = 8'd0;
        p_a_last  = 1'b0;
        p_s_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_held_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/caminho_saida_lifo.md
Name: caminho_saida_lifo

Overview:
- Sits directly downstream of gerenciador_memoria_anterior.
- That block rebuilds the shortest path by walking predecessor addresses from DESTINO back to FONTE, so nodes arrive in reverse order.
- This block buffers one complete path in a LIFO and streams it out FONTE-first over a valid/ready interface.
- It also reports path length and a completion pulse.

Parameters:
- ADDR_WIDTH, 8, width of one node address.
- MAX_CAMINHO, 64, maximum number of nodes in one path (LIFO depth).
- CNT_WIDTH, $clog2(MAX_CAMINHO+1), width of the occupancy and length counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- anterior_valid_in  input  1  path node presented by the reconstruction stage.
- anterior_addr_in  input  ADDR_WIDTH  node address (first node = DESTINO).
- anterior_last_in  input  1  marks final node (FONTE); qualified by valid.
- anterior_ready_out  output  1  block accepts a node this cycle.
- saida_valid_out  output  1  output node available.
- saida_addr_out  output  ADDR_WIDTH  output node address (first = FONTE).
- saida_last_out  output  1  marks DESTINO, the final output node.
- saida_ready_in  input  1  consumer accepts output node.
- tamanho_out  output  CNT_WIDTH  node count of the last completed path.
- pronto_out  output  1  one-cycle pulse after the final output handshake.
- erro_out  output  1  sticky overflow flag.

Behaviour:
- Storage: register array mem[MAX_CAMINHO], pointer ptr (CNT_WIDTH), FSM {S_CARREGA, S_DESCARREGA}.
- Reset (rst=1 at a clock edge):
  - state=S_CARREGA, ptr=0, tamanho_out=0, erro_out=0, pronto_out=0.
  - Outputs the cycle after reset: anterior_ready_out=1, saida_valid_out=0, saida_last_out=0, saida_addr_out=0.
  - Reset mid-operation discards any partial or unsent path; mem contents need not be cleared.
- S_CARREGA:
  - anterior_ready_out=1, saida_valid_out=0.
  - On valid_in&&ready_out with ptr<MAX_CAMINHO: mem[ptr]<=addr_in, ptr<=ptr+1.
  - Push attempted with ptr==MAX_CAMINHO: data dropped, erro_out<=1 (sticky until rst), ptr unchanged. Ready stays 1 so upstream never deadlocks.
  - On an accepted node with last_in=1, no overflow during this path:
    - tamanho_out<=ptr+1; the last node itself is stored.
    - state<=S_DESCARREGA.
  - On an accepted node with last_in=1 after an overflow in this path:
    - ptr<=0, stay in S_CARREGA; no output, no pronto, tamanho_out unchanged.
    - erro_out remains set.
  - A per-path overflow flag is cleared on every accepted last.
- S_DESCARREGA:
  - anterior_ready_out=0; upstream must hold its data.
  - saida_valid_out=1.
  - saida_addr_out=mem[ptr-1], read combinationally from registered state.
  - saida_last_out=(ptr==1).
  - First output valid exactly 1 cycle after the accepting edge of the last input node.
  - On saida_valid_out&&saida_ready_in: ptr<=ptr-1.
  - While valid&&!ready: addr and last held stable.
  - Handshake with last=1: ptr<=0, state<=S_CARREGA, pronto_out<=1 for exactly the next cycle.
  - A new path can be accepted in that same next cycle.
- Throughput: 1 node/cycle in both directions; no bubbles between outputs while ready_in=1.
- Single-node path (FONTE==DESTINO): one push with last → one output with last=1, tamanho_out=1.
- Output order is the exact reverse of input order; no duplication or loss under any ready pattern.

Test Plan:
- Push 5,9,12,3 (last on 3), ready_in=1:
  - Outputs 3,12,9,5 on consecutive cycles, last=1 with 5.
  - First valid 1 cycle after the handshake on 3.
  - tamanho_out=4; pronto_out high one cycle after the 5 handshake.
- Single node 7 with last → one output 7 with last=1, tamanho_out=1, pronto pulse; anterior_ready_out returns to 1.
- Backpressure on path 5,9,12,3 with ready_in pattern 1,0,0,1,0,1,1:
  - addr stable while stalled; sequence still 3,12,9,5.
  - Exactly four handshakes.
- MAX_CAMINHO=4, push 1..5 with last on 5:
  - erro_out=1, saida_valid_out never asserted, tamanho_out unchanged.
  - Next path 8,2 (last) outputs 2,8 and erro_out stays 1.
- Reset mid-unload after 2 of 4 nodes popped:
  - Next cycle saida_valid_out=0, anterior_ready_out=1, tamanho_out=0, erro_out=0.
  - Fresh path 4,6 then outputs 6,4.
- anterior_valid_in=1 (addr 11) held during S_DESCARREGA:
  - Not accepted while ready_out=0.
  - Accepted in the pronto_out cycle and later emitted correctly.
